// File: rtl/dmem_access_ctrl.sv
// Memory-stage data memory access controller: one load/store in flight, single-cycle response.
// Optional alignment fault on addr[2:0] != 0 when DMEM_ALIGN_CHECK_EN is defined.
module dmem_access_ctrl #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_fault,
  output logic [63:0] rsp_rdata,
  output logic        stall,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RSP
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [63:0]      wdata_q;
  logic             rsp_valid_q;
  logic             rsp_fault_q;
  logic [63:0]      rsp_rdata_q;

  logic [IDX_W-1:0] req_idx;
  logic             range_fault;
  logic             align_fault;
  logic             req_fault;

  assign req_idx     = req_addr[IDX_W+2:3];
  assign range_fault = (req_addr >> 3) >= 64'(DEPTH);

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_fault = |req_addr[2:0];
`else
  // Byte offset is truncated in this build.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^req_addr[2:0];
  assign align_fault     = 1'b0;
`endif

  assign req_fault = range_fault | align_fault;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
            if (req_fault) begin
              state_q     <= S_RSP;
              rsp_valid_q <= 1'b1;
              rsp_fault_q <= 1'b1;
              if (!req_write) rsp_rdata_q <= '0;
            end else begin
              state_q <= req_write ? S_WR : S_RD;
            end
          end
        end
        S_RD: state_q <= S_CAP;
        S_CAP: begin
          // Memory output is registered, so valid data is only present here.
          state_q     <= S_RSP;
          rsp_rdata_q <= mem_read_data;
          rsp_valid_q <= 1'b1;
          rsp_fault_q <= 1'b0;
        end
        S_WR: begin
          state_q     <= S_RSP;
          rsp_valid_q <= 1'b1;
          rsp_fault_q <= 1'b0;
        end
        S_RSP: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_fault_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign stall          = (state_q != S_IDLE) | (req_valid & ~req_ready);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_fault      = rsp_fault_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign mem_read       = (state_q == S_RD) & ~reset;
  assign mem_write      = (state_q == S_WR) & ~reset;
  assign mem_address    = {{(64-IDX_W){1'b0}}, idx_q};
  assign mem_write_data = wdata_q;

endmodule
